// File: rtl/mux16_rr_sched_pkg.sv
// rtl/mux16_rr_sched_pkg.sv - shared sizes and state encoding for the mux16 round-robin scheduler
package mux16_rr_sched_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// rtl/mux16_rr_sched_rr_pick16.sv - combinational round-robin picker, first set req after last
module rr_pick16
   import mux16_rr_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [4:0]       shift;
   logic [31:0]      dbl;
   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] low;

   always_comb begin
      // Rotating by last+1 puts the highest-priority candidate at bit 0.
      shift = {1'b0, last} + 5'd1;
      dbl   = {req, req} >> shift;
      rot   = dbl[N_REQ-1:0];
      low   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) low = SEL_W'(i);
      end
      any = |req;
      idx = low + last + 4'd1;
   end

endmodule

// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin slot scheduler driving a mux16to1 select; option MUX_SCHED_EARLY_RELEASE_EN
module mux16_rr_sched
   import mux16_rr_sched_pkg::*;
#(
   parameter int SLOT_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] grant,
   output logic             valid,
   output logic             slot_start
);

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SLOT_CYCLES - 1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [SEL_W-1:0] last, last_d;
   logic [SEL_W-1:0] sel_d;
   logic [N_REQ-1:0] grant_d;
   logic             valid_d, slot_start_d;
   logic             slot_end;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;

   rr_pick16 u_pick (
      .req  (req),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last       <= 4'd15;
         sel        <= '0;
         grant      <= '0;
         valid      <= 1'b0;
         slot_start <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         last       <= last_d;
         sel        <= sel_d;
         grant      <= grant_d;
         valid      <= valid_d;
         slot_start <= slot_start_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      last_d       = last;
      sel_d        = sel;
      grant_d      = grant;
      valid_d      = valid;
      slot_start_d = 1'b0;

      slot_end = (state == ST_HOLD) && (cnt == '0);
`ifdef MUX_SCHED_EARLY_RELEASE_EN
      // An abandoned slot ends immediately rather than running out its count.
      if ((state == ST_HOLD) && !req[sel]) slot_end = 1'b1;
`endif

      if (((state == ST_IDLE) || slot_end) && en && pick_any) begin
         state_d      = ST_HOLD;
         cnt_d        = CNT_RELOAD;
         last_d       = pick_idx;
         sel_d        = pick_idx;
         grant_d      = 16'd1 << pick_idx;
         valid_d      = 1'b1;
         slot_start_d = 1'b1;
      end else if (slot_end) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         grant_d = '0;
         valid_d = 1'b0;
      end else if (state == ST_HOLD) begin
         cnt_d = cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb/tb_mux16_rr_sched.sv - self-checking bench for mux16_rr_sched against a slot-level reference model
module tb_mux16_rr_sched;

   localparam int SLOT = 4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] req;
   logic [3:0]  sel;
   logic [15:0] grant;
   logic        valid;
   logic        slot_start;

   int checks   = 0;
   int failures = 0;

   // Reference model: cycles left in the current slot (0 = idle), owner and last winner.
   int       m_left;
   int       m_sel;
   int       m_last;
   bit       m_start;

   mux16_rr_sched #(.SLOT_CYCLES(SLOT), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req        (req),
      .sel        (sel),
      .grant      (grant),
      .valid      (valid),
      .slot_start (slot_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_left  = 0;
      m_sel   = 0;
      m_last  = 15;
      m_start = 0;
   endtask

   task automatic model_edge(input logic [15:0] r, input logic e);
      bit fin;
      fin = (m_left <= 1);
`ifdef MUX_SCHED_EARLY_RELEASE_EN
      if (m_left > 0 && r[m_sel] == 1'b0) fin = 1;
`endif
      m_start = 0;
      if (!fin) begin
         m_left = m_left - 1;
      end else if (e && r != 16'h0) begin
         for (int k = 1; k <= 16; k++) begin
            if (r[(m_last + k) % 16]) begin
               m_sel = (m_last + k) % 16;
               break;
            end
         end
         m_last  = m_sel;
         m_left  = SLOT;
         m_start = 1;
      end else begin
         m_left = 0;
      end
   endtask

   function automatic logic [21:0] model_vec();
      logic [15:0] g;
      g = (m_left > 0) ? (16'd1 << m_sel) : 16'h0;
      return {(m_left > 0), m_start, 4'(m_sel), g};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge(req, en);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      en    = 1'b0;
      req   = 16'h0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({valid, slot_start, sel, grant} !== 22'h0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", {valid, slot_start, sel, grant}, 22'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if ({valid, slot_start, sel, grant} !== 22'h0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, {valid, slot_start, sel, grant}, 22'h0);
         end
      end
   endtask

   task automatic test_single();
      int starts;
      do_reset();
      en     = 1'b1;
      req    = 16'h0001;
      starts = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         checks++;
         if ({valid, slot_start, sel, grant} !== {1'b1, (c % SLOT == 0), 4'd0, 16'h0001}) begin
            failures++;
            $display("FAIL single cyc=%0d got=%h exp=%h", c, {valid, slot_start, sel, grant},
                     {1'b1, (c % SLOT == 0), 4'd0, 16'h0001});
         end
      end
   endtask

   task automatic test_pattern();
      int seq[$];
      int exp_seq[5] = '{0, 5, 10, 15, 0};
      do_reset();
      en  = 1'b1;
      req = 16'h8421;
      for (int c = 0; c < 5 * SLOT; c++) begin
         step();
         if (slot_start) seq.push_back(int'(sel));
         checks++;
         if ({valid, slot_start, sel, grant} !== model_vec()) begin
            failures++;
            $display("FAIL pattern cyc=%0d got=%h exp=%h", c, {valid, slot_start, sel, grant}, model_vec());
         end
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= seq.size() || seq[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL pattern_seq i=%0d got=%0d exp=%0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int seq[$];
      int exp_seq[3] = '{0, 15, 0};
      do_reset();
      en  = 1'b1;
      req = 16'h8421;
      for (int c = 0; c < 3 * SLOT + 1; c++) step();
      checks++;
      if (sel !== 4'd15 || !slot_start) begin
         failures++;
         $display("FAIL wrap_setup got sel=%0d start=%0b exp sel=15 start=1", sel, slot_start);
      end
      req = 16'h8001;
      for (int c = 0; c < 4 * SLOT - 1; c++) begin
         step();
         if (slot_start) seq.push_back(int'(sel));
         checks++;
         if ({valid, slot_start, sel, grant} !== model_vec()) begin
            failures++;
            $display("FAIL wrap cyc=%0d got=%h exp=%h", c, {valid, slot_start, sel, grant}, model_vec());
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= seq.size() || seq[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL wrap_seq i=%0d got=%0d exp=%0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
         end
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      en  = 1'b1;
      req = 16'h8421;
      for (int c = 0; c < SLOT + 2; c++) step();
      en = 1'b0;
      for (int c = 0; c < SLOT + 2; c++) begin
         step();
         checks++;
         if ({valid, slot_start, sel, grant} !== model_vec()) begin
            failures++;
            $display("FAIL en_drop cyc=%0d got=%h exp=%h", c, {valid, slot_start, sel, grant}, model_vec());
         end
      end
      checks++;
      if (valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd5) begin
         failures++;
         $display("FAIL en_drop_idle got v=%0b g=%h s=%0d exp v=0 g=0000 s=5", valid, grant, sel);
      end
      en = 1'b1;
      step();
      checks++;
      if ({valid, slot_start, sel, grant} !== {1'b1, 1'b1, 4'd10, 16'h0400}) begin
         failures++;
         $display("FAIL en_resume got=%h exp=%h", {valid, slot_start, sel, grant}, {1'b1, 1'b1, 4'd10, 16'h0400});
      end
      step();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({valid, slot_start, sel, grant} !== 22'h0) begin
         failures++;
         $display("FAIL reset_midslot got=%h exp=%h", {valid, slot_start, sel, grant}, 22'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      checks++;
      if ({valid, slot_start, sel, grant} !== {1'b1, 1'b1, 4'd0, 16'h0001}) begin
         failures++;
         $display("FAIL reset_regrant got=%h exp=%h", {valid, slot_start, sel, grant}, {1'b1, 1'b1, 4'd0, 16'h0001});
      end
   endtask

`ifdef MUX_SCHED_EARLY_RELEASE_EN
   task automatic test_early_release();
      do_reset();
      en  = 1'b1;
      req = 16'h8421;
      for (int c = 0; c < SLOT + 2; c++) step();
      req = 16'h8401;
      step();
      checks++;
      if ({valid, slot_start, sel, grant} !== {1'b1, 1'b1, 4'd10, 16'h0400}) begin
         failures++;
         $display("FAIL early_release got=%h exp=%h", {valid, slot_start, sel, grant}, {1'b1, 1'b1, 4'd10, 16'h0400});
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0: req = 16'h0;
               1: req = 16'd1 << $urandom_range(0, 15);
               2: req = 16'($urandom & $urandom & $urandom);
               default: req = 16'($urandom);
            endcase
         end
         en = ($urandom_range(0, 7) != 0);
         step();
         checks++;
         if ({valid, slot_start, sel, grant} !== model_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d req=%h got=%h exp=%h", c, req, {valid, slot_start, sel, grant}, model_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_pattern();
      test_wrap();
      test_en_drop();
`ifdef MUX_SCHED_EARLY_RELEASE_EN
      test_early_release();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
